// File: rtl/recip_freq_meter.sv
// Reciprocal (equal-precision) frequency meter.
// A preset gate of gate_len clk cycles is armed. The real gate opens on the
// first synchronised rising edge of sig_in and closes on the first rising
// edge after the preset gate has expired. This gives a whole number of
// signal periods, so the count ratio is exact: f = F_CLK * nx / nref.
module recip_freq_meter #(
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic              mode_cont,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic [CNT_W-1:0]  nx,
  output logic [CNT_W-1:0]  nref,
  output logic              valid,
  output logic              ovf,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_CLOSE,
    S_DONE
  } state_t;

  // A count of one, used when the gate opens and for a zero gate length.
  localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
  localparam logic [GATE_W-1:0] ONE_GATE = GATE_W'(1);
  // Watchdog margin, in the widened (carry-preserving) compare width.
  localparam logic [GATE_W:0]   TMO_W    = (GATE_W + 1)'(TIMEOUT_CYC);

  state_t state_q, state_d;

  // Input synchroniser plus one history flop for rising-edge detection.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise;

  // Preset gate: length, elapsed count and registered expiry flag.
  logic [GATE_W-1:0] glen_q, glen_d;
  logic [GATE_W-1:0] gcnt_q, gcnt_d;
  logic              gate_done_q, gate_done_d;

  // Watchdog counter; one bit wider so glen + margin cannot wrap.
  logic [GATE_W:0]   wdog_q, wdog_d;
  logic [GATE_W:0]   wdog_lim;
  logic              wdog_hit;

  // Working counters of the open gate and their sticky status flags.
  logic [CNT_W-1:0]  cx_q, cx_d;
  logic [CNT_W-1:0]  cref_q, cref_d;
  logic              ovf_int_q, ovf_int_d;
  logic              tmo_int_q, tmo_int_d;

  // Result registers that hold between valid strobes.
  logic [CNT_W-1:0]  nx_q, nx_d;
  logic [CNT_W-1:0]  nref_q, nref_d;
  logic              ovf_q, ovf_d;
  logic              timeout_q, timeout_d;

  logic              arm_entry;
  logic              in_gate;

  // Synchroniser shift and edge detect on the last synchronised stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Watchdog limit: the preset gate plus the allowed no-edge margin.
  always_comb begin
    wdog_lim = {1'b0, glen_q} + TMO_W;
    wdog_hit = (wdog_q == wdog_lim);
  end

  // Next-state, counters and result capture.
  always_comb begin
    state_d     = state_q;
    glen_d      = glen_q;
    gcnt_d      = gcnt_q;
    gate_done_d = gate_done_q;
    wdog_d      = wdog_q;
    cx_d        = cx_q;
    cref_d      = cref_q;
    ovf_int_d   = ovf_int_q;
    tmo_int_d   = tmo_int_q;
    nx_d        = nx_q;
    nref_d      = nref_q;
    ovf_d       = ovf_q;
    timeout_d   = timeout_q;
    arm_entry   = 1'b0;
    in_gate     = (state_q == S_ARM) || (state_q == S_MEAS);

    // Preset gate and watchdog run through both ARM and MEAS.
    if (in_gate) begin
      if (gcnt_q != glen_q) begin
        gcnt_d = gcnt_q + 1'b1;
      end
      gate_done_d = (gcnt_q == glen_q);
      wdog_d      = wdog_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ARM;
          arm_entry = 1'b1;
        end
      end

      S_ARM: begin
        if (wdog_hit) begin
          tmo_int_d = 1'b1;
          state_d   = S_CLOSE;
        end else if (rise) begin
          // The opening edge itself starts the first reference period.
          cx_d    = '0;
          cref_d  = ONE_CNT;
          state_d = S_MEAS;
        end
      end

      S_MEAS: begin
        if (gate_done_q && rise) begin
          // Closing edge: count the last period, reference stays put.
          if (&cx_q) begin
            ovf_int_d = 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
          state_d = S_CLOSE;
        end else if (wdog_hit) begin
          tmo_int_d = 1'b1;
          state_d   = S_CLOSE;
        end else begin
          if (&cref_q) begin
            ovf_int_d = 1'b1;
          end else begin
            cref_d = cref_q + 1'b1;
          end
          if (rise) begin
            if (&cx_q) begin
              ovf_int_d = 1'b1;
            end else begin
              cx_d = cx_q + 1'b1;
            end
          end
        end
      end

      S_CLOSE: begin
        // An aborted measurement reports zero counts.
        nx_d      = tmo_int_q ? '0 : cx_q;
        nref_d    = tmo_int_q ? '0 : cref_q;
        ovf_d     = ovf_int_q;
        timeout_d = tmo_int_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        // start is not looked at here; only mode_cont decides re-arming.
        if (mode_cont) begin
          state_d   = S_ARM;
          arm_entry = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Fresh gate on every ARM entry; a zero length counts as one cycle.
    if (arm_entry) begin
      glen_d      = (gate_len == '0) ? ONE_GATE : gate_len;
      gcnt_d      = '0;
      gate_done_d = 1'b0;
      wdog_d      = '0;
      ovf_int_d   = 1'b0;
      tmo_int_d   = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      glen_q      <= '0;
      gcnt_q      <= '0;
      gate_done_q <= 1'b0;
      wdog_q      <= '0;
      cx_q        <= '0;
      cref_q      <= '0;
      ovf_int_q   <= 1'b0;
      tmo_int_q   <= 1'b0;
      nx_q        <= '0;
      nref_q      <= '0;
      ovf_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      glen_q      <= glen_d;
      gcnt_q      <= gcnt_d;
      gate_done_q <= gate_done_d;
      wdog_q      <= wdog_d;
      cx_q        <= cx_d;
      cref_q      <= cref_d;
      ovf_int_q   <= ovf_int_d;
      tmo_int_q   <= tmo_int_d;
      nx_q        <= nx_d;
      nref_q      <= nref_d;
      ovf_q       <= ovf_d;
      timeout_q   <= timeout_d;
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    busy    = (state_q == S_ARM) || (state_q == S_MEAS) || (state_q == S_CLOSE);
    valid   = (state_q == S_DONE);
    nx      = nx_q;
    nref    = nref_q;
    ovf     = ovf_q;
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_recip_freq_meter.sv
// Directed bench for recip_freq_meter: a 32-bit and an 8-bit instance share
// all inputs; sig_in is a square wave generated on clk falling edges so the
// first synchronised rise lands a fixed number of cycles after ARM entry.
module tb_recip_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        mode_cont;
  logic [31:0] gate_len;

  logic        busy, valid, ovf, timeout;
  logic [31:0] nx, nref;
  logic        busy8, valid8, ovf8, timeout8;
  logic [7:0]  nx8, nref8;

  int n_cmp = 0;
  int n_bad = 0;

  bit sig_en  = 1'b0;
  int sig_per = 10;
  int sig_hi  = 5;

  always #5 clk = ~clk;

  recip_freq_meter #(
    .CNT_W(32), .GATE_W(32), .SYNC_STAGES(2), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .mode_cont(mode_cont), .gate_len(gate_len), .busy(busy),
    .nx(nx), .nref(nref), .valid(valid), .ovf(ovf), .timeout(timeout)
  );

  recip_freq_meter #(
    .CNT_W(8), .GATE_W(32), .SYNC_STAGES(2), .TIMEOUT_CYC(100)
  ) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .mode_cont(mode_cont), .gate_len(gate_len), .busy(busy8),
    .nx(nx8), .nref(nref8), .valid(valid8), .ovf(ovf8), .timeout(timeout8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Square-wave source; restarts its phase whenever it is disabled.
  initial begin
    int ph;
    ph     = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!sig_en) begin
        sig_in = 1'b0;
        ph     = 0;
      end else begin
        sig_in = (ph < sig_hi);
        ph     = (ph + 1 >= sig_per) ? 0 : ph + 1;
      end
    end
  end

  // Start a measurement. ARM entry is the start-sampling edge (cycle 0);
  // the wave goes high during cycle 1, so the first rise is seen in cycle 3.
  task automatic launch(input logic [31:0] glen, input bit cont, input bit sig_on,
                        input int per, input int hi);
    sig_en    = 1'b0;
    sig_per   = per;
    sig_hi    = hi;
    gate_len  = glen;
    mode_cont = cont;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 sig_en = sig_on;
  endtask

  // Wait for valid, returning the cycle index it appeared in, or -1.
  task automatic wait_valid(input bit use8, input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if ((use8 ? valid8 : valid) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    start     = 1'b0;
    mode_cont = 1'b0;
    gate_len  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_nx", nx, 0);
    chk("rst_nref", nref, 0);
    chk("rst_flags", {ovf, timeout}, 0);
    rst = 1'b0;

    // Single shot, gate 100, period 10; a start mid-measurement is ignored.
    launch(32'd100, 1'b0, 1'b1, 10, 5);
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(1'b0, 300, lat);
    chk("ss_got_valid", (lat >= 0), 1);
    chk("ss_nx", nx, 10);
    chk("ss_nref", nref, 100);
    chk("ss_ovf", ovf, 0);
    chk("ss_timeout", timeout, 0);
    @(negedge clk);
    chk("ss_valid_1cyc", valid, 0);
    chk("ss_busy_low", busy, 0);

    // Continuous mode, gate 1000, period 7: back-to-back results.
    launch(32'd1000, 1'b1, 1'b1, 7, 3);
    for (int m = 0; m < 3; m++) begin
      wait_valid(1'b0, 1200, lat);
      chk($sformatf("cont%0d_latency", m), lat, (m == 0) ? 1006 : 1008);
      chk($sformatf("cont%0d_nx", m), nx, 143);
      chk($sformatf("cont%0d_nref", m), nref, 1001);
      chk($sformatf("cont%0d_ratio", m), (nref == 32'd7 * nx), 1);
    end
    repeat (100) @(negedge clk);
    mode_cont = 1'b0;
    wait_valid(1'b0, 1200, lat);
    chk("cont_last_valid", (lat >= 0), 1);
    chk("cont_last_nx", nx, 143);
    @(negedge clk);
    chk("cont_stop_busy", busy, 0);
    wait_valid(1'b0, 1200, lat);
    chk("cont_no_more_valid", lat, -1);

    // No signal: watchdog aborts after gate 50 + margin 100.
    launch(32'd50, 1'b0, 1'b0, 10, 5);
    wait_valid(1'b0, 400, lat);
    chk("tmo_latency_in_window", (lat >= 150 && lat <= 152), 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_nx", nx, 0);
    chk("tmo_nref", nref, 0);
    chk("tmo_ovf", ovf, 0);

    // 8-bit counters: nref saturates, gate still closes on an edge.
    launch(32'd1000, 1'b0, 1'b1, 4, 2);
    wait_valid(1'b1, 1200, lat);
    chk("sat_got_valid", (lat >= 0), 1);
    chk("sat_nref8", nref8, 255);
    chk("sat_nx8", nx8, 250);
    chk("sat_ovf8", ovf8, 1);
    chk("sat_timeout8_cleared", timeout8, 0);
    chk("sat_nref32", nref, 1000);
    chk("sat_ovf32", ovf, 0);
    @(negedge clk);
    chk("sat_valid8_1cyc", valid8, 0);

    // Reset in the middle of a measurement.
    launch(32'd1000, 1'b0, 1'b1, 10, 5);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_nx", nx, 0);
    chk("mrst_nref", nref, 0);
    chk("mrst_ovf8", ovf8, 0);
    chk("mrst_valid", valid, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    chk("mrst_no_valid", seen, 0);
    launch(32'd100, 1'b0, 1'b1, 10, 5);
    wait_valid(1'b0, 300, lat);
    chk("mrst_fresh_nx", nx, 10);
    chk("mrst_fresh_nref", nref, 100);

    // Zero gate length behaves as a one-cycle gate.
    launch(32'd0, 1'b0, 1'b1, 2, 1);
    wait_valid(1'b0, 50, lat);
    chk("g0_latency", lat, 7);
    chk("g0_nx", nx, 1);
    chk("g0_nref", nref, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
